// File: rtl/sram_sp_4096x16.sv
// Behavioural single-port 4096x16 synchronous SRAM, modelled on the SHAB90 hard macro.
// Registered read with write-through; dout is combinationally gated by oe.
module sram_sp_4096x16 #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] di,
  output logic [DATA_W-1:0] dout,
  input  logic              web,
  input  logic              oe,
  input  logic              cs
);

  // The address must decode the whole array with no aliasing.
  if (DEPTH != (1 << ADDR_W)) begin : g_param_check
    $error("sram_sp_4096x16: DEPTH (%0d) must equal 2**ADDR_W (%0d)", DEPTH, 1 << ADDR_W);
  end

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] dout_q;
  logic              wr_en_d;
  logic              rd_en_d;

  // Accesses presented while reset is asserted are dropped entirely.
  always_comb begin
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    if (rst_n && cs) begin
      wr_en_d = ~web;
      rd_en_d = web;
    end
  end

  // Array has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      mem[a] <= di;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (wr_en_d) begin
      dout_q <= di;
    end else if (rd_en_d) begin
      dout_q <= mem[a];
    end
  end

  assign dout = oe ? dout_q : '0;

`ifndef SYNTHESIS
  // Simulation-only access statistics; call report_access_counts() to print them.
  int unsigned wr_count_q = 0;
  int unsigned rd_count_q = 0;

  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      wr_count_q <= wr_count_q + 1;
    end
    if (rd_en_d) begin
      rd_count_q <= rd_count_q + 1;
    end
  end

  task automatic report_access_counts();
    $display("sram_sp_4096x16 %m: writes=%0d reads=%0d", wr_count_q, rd_count_q);
  endtask
`endif

endmodule

// File: tb/tb_sram_sp_4096x16.sv
// Scoreboard bench for sram_sp_4096x16: stimulus pushes expected dout per cycle,
// a monitor one step after each rising edge pops and compares.
module tb_sram_sp_4096x16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b0;
  logic        web = 1'b1;
  logic        oe = 1'b1;
  logic [11:0] a = '0;
  logic [15:0] di = '0;
  logic [15:0] dout;

  always #5 clk = ~clk;

  sram_sp_4096x16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .di    (di),
    .dout  (dout),
    .web   (web),
    .oe    (oe),
    .cs    (cs)
  );

  typedef struct {
    logic [15:0] val;
    bit          known;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: sparse word store plus the last value the read port produced.
  logic [15:0] ref_mem [int];
  logic [15:0] ref_out = '0;
  bit          ref_known = 1'b0;

  task automatic step(input bit rst, input bit c, input bit w, input bit o,
                      input logic [11:0] ad, input logic [15:0] d, input string nm);
    exp_t e;
    @(negedge clk);
    rst_n = ~rst;
    cs    = c;
    web   = w;
    oe    = o;
    a     = ad;
    di    = d;
    if (rst) begin
      ref_out   = '0;
      ref_known = 1'b1;
    end else if (c) begin
      if (!w) begin
        ref_mem[int'(ad)] = d;
        ref_out   = d;
        ref_known = 1'b1;
      end else if (ref_mem.exists(int'(ad))) begin
        ref_out   = ref_mem[int'(ad)];
        ref_known = 1'b1;
      end else begin
        ref_known = 1'b0;
      end
    end
    e.val   = o ? ref_out : 16'h0000;
    e.known = !o || ref_known;
    e.name  = nm;
    exp_q.push_back(e);
  endtask

  task automatic check_now(input logic [15:0] expv, input string nm);
    checks++;
    if (dout !== expv) begin
      errors++;
      $display("FAIL %s: dout=%h expected=%h t=%0t", nm, dout, expv, $time);
    end else begin
      $display("ok   %s: dout=%h t=%0t", nm, dout, $time);
    end
  endtask

  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.known) begin
        checks++;
        if (dout !== mon_e.val) begin
          errors++;
          $display("FAIL %s: dout=%h expected=%h a=%h t=%0t", mon_e.name, dout, mon_e.val, a, $time);
        end else begin
          $display("ok   %s: dout=%h a=%h t=%0t", mon_e.name, dout, a, $time);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] ia;
    logic [11:0] ra;
    bit          rr;
    // Power-on reset, then seed 0x005 so its survival across reset is observable.
    step(1, 0, 1, 1, 12'h000, 16'h0000, "por");
    step(1, 0, 1, 1, 12'h000, 16'h0000, "por");
    step(0, 1, 0, 1, 12'h005, 16'h2222, "seed_005");
    step(1, 1, 0, 1, 12'h005, 16'h1111, "rst_wr_drop");
    step(1, 1, 0, 1, 12'h005, 16'h1111, "rst_wr_drop");
    step(0, 1, 1, 1, 12'h005, 16'h0000, "rd_005_after_rst");

    // Address extremes, read back on consecutive cycles.
    step(0, 1, 0, 1, 12'h000, 16'hABCD, "wr_000");
    step(0, 1, 0, 1, 12'hFFF, 16'h1234, "wr_fff");
    step(0, 1, 1, 1, 12'h000, 16'h0000, "rd_000");
    step(0, 1, 1, 1, 12'hFFF, 16'h0000, "rd_fff");

    // Full fill and pipelined sweep.
    for (int i = 0; i < 4096; i++) begin
      ia = i[11:0];
      step(0, 1, 0, 1, ia, {ia[7:0], ~ia[7:0]}, "fill");
    end
    for (int i = 0; i < 4096; i++) begin
      ia = i[11:0];
      step(0, 1, 1, 1, ia, 16'h0000, "sweep");
    end

    // Write-through.
    step(0, 1, 0, 1, 12'h010, 16'h00FF, "wr_010");
    step(0, 1, 0, 1, 12'h010, 16'h5A5A, "wthru_010");
    step(0, 1, 1, 1, 12'h010, 16'h0000, "rd_010");

    // Chip select low blocks writes and reads.
    step(0, 1, 0, 1, 12'h020, 16'h7777, "wr_020");
    step(0, 1, 1, 1, 12'h005, 16'h0000, "rd_005");
    step(0, 0, 0, 1, 12'h020, 16'h0000, "cs0_wr_hold");
    step(0, 0, 1, 1, 12'h020, 16'h0000, "cs0_rd_hold");
    step(0, 1, 1, 1, 12'h020, 16'h0000, "rd_020");

    // Output enable gates combinationally.
    step(0, 1, 0, 1, 12'h030, 16'hBEEF, "wr_030");
    step(0, 1, 1, 1, 12'h030, 16'h0000, "rd_030");
    step(0, 0, 1, 0, 12'h030, 16'h0000, "oe_low");
    #1 check_now(16'h0000, "oe_low_immediate");
    step(0, 0, 1, 1, 12'h030, 16'h0000, "oe_high");
    #1 check_now(16'hBEEF, "oe_high_immediate");

    // Random mix concentrated on a small window so reads hit written words.
    for (int i = 0; i < 2000; i++) begin
      ra = ($urandom_range(0, 15) == 0) ? 12'hFFF - 12'($urandom_range(0, 3))
                                        : 12'($urandom_range(0, 63));
      rr = ($urandom_range(0, 49) == 0);
      step(rr, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 7) != 0, ra, 16'($urandom()), "rand");
    end

    step(0, 0, 1, 1, 12'h000, 16'h0000, "idle");
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    dut.report_access_counts();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_sp_4096x16.md
Name: sram_sp_4096x16

Overview:
- Single-port synchronous SRAM, 4096 words x 16 bits.
- Behavioural model of the SHAB90_4096X16X1CM16 hard macro.
- Used as the point buffer of the k-means engine. Points are written once during data input, then read sequentially on every clustering pass.
- One access per cycle (read or write) on a shared address.

Parameters:
- DEPTH, 4096, number of words.
- ADDR_W, 12, address width; DEPTH = 2^ADDR_W.
- DATA_W, 16, word width; bits [15:8] = x, bits [7:0] = y (packing is meaningless to the memory).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- a  input  12  word address.
- di  input  16  write data.
- dout  output  16  read data (output of the SHAB90 DO pin).
- web  input  1  write enable, active-low.
- oe  input  1  output enable, active-high.
- cs  input  1  chip select, active-high.

Behaviour:
- Reset and clock: reset rst_n, synchronous, active-low; clock clk.
- Reset action (rst_n=0 at the edge): output register <= 0; no write occurs regardless of web/cs. Array contents are not cleared and keep their values across reset.
- Reset mid-operation: any access presented in a reset cycle is dropped. The first access after reset is taken on the first edge with rst_n=1.
- Access is taken only when cs=1 at the rising edge. When cs=0: no write, no read, output register holds its value.
- Write (cs=1, web=0): mem[a] <= di at the edge.
- Read (cs=1, web=1): output register <= mem[a] at the edge. dout is valid after that edge, i.e. 1-cycle latency from address to data.
- Read-during-write (cs=1, web=0): write-through. The output register also loads di, so dout shows the newly written data after the edge.
- Pipelined reads: a new address every cycle gives one new word every cycle, each delayed by exactly one edge.
- Output gating is combinational: dout = oe ? output_register : 16'h0000. oe does not affect the array or the register.
- Address: all 12 bits are decoded; no wrap or aliasing. a=0xFFF is the last word.
- Uninitialised reads: reading a never-written word returns undefined data (X in simulation). Software and the bench must not depend on it.
- No X-propagation protection on a/di beyond normal simulator semantics.
- Implementation:
  - Array is a reg [DATA_W-1:0] mem [0:DEPTH-1].
  - Output register is the only resettable state.
  - Also include a parameter-checked assertion block: DEPTH == 2^ADDR_W, flagged at time 0.
  - Include a simulation-only access counter/monitor (writes, reads) reported via $display on request.

Test Plan:
- Reset: rst_n=0 for 2 cycles with cs=1, web=0, a=0x005, di=0x1111 -> dout=0x0000. Then, after reset, read 0x005 returns its pre-reset content, i.e. no write happened.
- Write 0xABCD to 0x000 and 0x1234 to 0xFFF, then read 0x000, 0xFFF on consecutive cycles -> dout=0xABCD one cycle after the first read, then 0x1234 the next cycle.
- Sequential fill-and-readback:
  - Write mem[i] = {i[7:0], ~i[7:0]} for i=0..4095 with web=0 every cycle.
  - Then set web=1 and sweep a=0..4095 -> each word appears exactly one cycle after its address; all 4096 match.
- Read-during-write: mem[0x010]=0x00FF, then cs=1, web=0, a=0x010, di=0x5A5A -> dout=0x5A5A after the edge. A following read of 0x010 also gives 0x5A5A.
- Chip select: mem[0x020]=0x7777, then cs=0, web=0, a=0x020, di=0x0000 -> dout unchanged and a later read of 0x020 gives 0x7777. With cs=0 and web=1, dout holds its previous value.
- Output enable: after a read returning 0xBEEF, drop oe=0 -> dout=0x0000 immediately. Raise oe=1 -> 0xBEEF again with no extra clock.
